// File: rtl/bitty_pkg.sv
// Shared constants and fetch-state encoding for the bitty core front end.
package bitty_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        EXEC = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/bitty_fetch_unit.sv
// Program counter and instruction-fetch stage: fetches the word at pc, holds it for the core
// and branch_logic until en_pc loads the next pc, and counts accepted en_pc events.
module bitty_fetch_unit #(
    parameter int              PC_W     = bitty_pkg::PC_W,
    parameter int              INSTR_W  = bitty_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = bitty_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   en_pc,
    input  logic [PC_W-1:0]        new_pc,
    output logic                   mem_req,
    output logic [PC_W-1:0]        mem_addr,
    input  logic [INSTR_W-1:0]     mem_rdata,
    input  logic                   mem_valid,
    output logic [INSTR_W-1:0]     instruction,
    output logic [PC_W-1:0]        pc,
    output logic                   instr_valid,
    output logic [CNT_W-1:0]       instr_count,
    output bitty_pkg::fetch_state_e dbg_state
);
    import bitty_pkg::*;

    // Memory handshake: mem_req is a single-cycle pulse with mem_addr=pc; mem_addr stays put
    // until the one-cycle mem_valid is seen in WAIT. mem_valid in any other state is dropped.
    fetch_state_e         state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (run) state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                if (mem_valid) begin
                    instr_d = mem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // run=0 here can only happen if upstream fails to gate en_pc
                if (en_pc) begin
                    pc_d    = new_pc;
                    count_d = count_q + CNT_W'(1);
                    state_d = run ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == EXEC);
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Directed bench for bitty_fetch_unit with a variable-latency instruction memory model.
module tb_bitty_fetch_unit;
    import bitty_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        en_pc;
    logic [7:0]  new_pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] instruction;
    logic [7:0]  pc;
    logic        instr_valid;
    logic [15:0] instr_count;
    fetch_state_e dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int lat          = 1;
    int stray_cnt    = 0;
    int exp_cnt      = 0;
    logic [15:0] mem [256];

    bitty_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .run(run), .en_pc(en_pc), .new_pc(new_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .instruction(instruction), .pc(pc), .instr_valid(instr_valid),
        .instr_count(instr_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: reacts 1ns after each rising edge; mem_valid arrives lat cycles after mem_req
    initial begin
        int pending;
        int cnt;
        int stray_seen;
        pending    = 0;
        cnt        = 0;
        stray_seen = 0;
        mem_valid  = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            if (!reset_n) begin
                pending = 0;
            end else if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                mem_valid  = 1'b1;
                mem_rdata  = 16'hDEAD;
            end else begin
                if (pending != 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        mem_valid = 1'b1;
                        mem_rdata = mem[mem_addr];
                        pending   = 0;
                    end
                end
                if (mem_req) begin
                    pending = 1;
                    cnt     = lat;
                end
            end
        end
    end

    task automatic wait_instr(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fire_en(input logic [7:0] npc);
        en_pc  = 1'b1;
        new_pc = npc;
        @(negedge clk);
        en_pc  = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        run     = 1'b1;
        en_pc   = 1'b0;
        new_pc  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (pc !== 8'h00 || instr_valid !== 1'b0 || mem_req !== 1'b0 ||
                instr_count !== 16'h0000 || dbg_state !== IDLE) begin
                tests_failed++;
                $display("FAIL reset_c%0d: pc=%h iv=%b req=%b cnt=%h st=%0d, want pc=00 iv=0 req=0 cnt=0000 st=0",
                         i, pc, instr_valid, mem_req, instr_count, dbg_state);
            end
        end
    endtask

    task automatic test_first_fetch;
        int cyc;
        bit ok;
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL first_req: req=%b addr=%h, want req=1 addr=00", mem_req, mem_addr);
        end
        wait_instr(cyc, ok);
        tests_run++;
        if (!ok || cyc != 2 || instruction !== 16'h0001 || pc !== 8'h00) begin
            tests_failed++;
            $display("FAIL first_instr: ok=%b cyc=%0d instr=%h pc=%h, want ok=1 cyc=2 instr=0001 pc=00",
                     ok, cyc, instruction, pc);
        end
        fire_en(8'h01);
        tests_run++;
        if (pc !== 8'h01 || instr_count !== 16'd1 || mem_req !== 1'b1 || mem_addr !== 8'h01 ||
            instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_en: pc=%h cnt=%0d req=%b addr=%h iv=%b, want pc=01 cnt=1 req=1 addr=01 iv=0",
                     pc, instr_count, mem_req, mem_addr, instr_valid);
        end
        wait_instr(cyc, ok);
        tests_run++;
        if (!ok || instruction !== 16'hA501) begin
            tests_failed++;
            $display("FAIL second_instr: ok=%b instr=%h, want ok=1 instr=a501", ok, instruction);
        end
    endtask

    task automatic test_latency;
        lat = 5;
        fire_en(8'h02);
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h02 || instr_count !== exp_cnt[15:0]) begin
            tests_failed++;
            $display("FAIL lat_req: req=%b addr=%h cnt=%0d, want req=1 addr=02 cnt=%0d",
                     mem_req, mem_addr, instr_count, exp_cnt);
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (i < 6) begin
                if (mem_req !== 1'b0 || mem_addr !== 8'h02 || instr_valid !== 1'b0 ||
                    mem_valid !== (i == 5)) begin
                    tests_failed++;
                    $display("FAIL lat_wait_c%0d: req=%b addr=%h iv=%b mv=%b, want req=0 addr=02 iv=0 mv=%0d",
                             i, mem_req, mem_addr, instr_valid, mem_valid, (i == 5));
                end
            end else if (instr_valid !== 1'b1 || instruction !== 16'hA502) begin
                tests_failed++;
                $display("FAIL lat_exec: iv=%b instr=%h, want iv=1 instr=a502", instr_valid, instruction);
            end
        end
        lat = 1;
    endtask

    task automatic test_branch;
        int cyc;
        bit ok;
        fire_en(8'h20);
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h20) begin
            tests_failed++;
            $display("FAIL br_req: req=%b addr=%h, want req=1 addr=20", mem_req, mem_addr);
        end
        wait_instr(cyc, ok);
        tests_run++;
        if (!ok || instruction !== 16'hA520) begin
            tests_failed++;
            $display("FAIL br_instr: ok=%b instr=%h, want ok=1 instr=a520", ok, instruction);
        end
        fire_en(8'hFF);
        wait_instr(cyc, ok);
        tests_run++;
        if (!ok || pc !== 8'hFF || instruction !== 16'hA5FF) begin
            tests_failed++;
            $display("FAIL br_ff: ok=%b pc=%h instr=%h, want ok=1 pc=ff instr=a5ff", ok, pc, instruction);
        end
        fire_en(8'h00);
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || pc !== 8'h00 || instr_count !== exp_cnt[15:0]) begin
            tests_failed++;
            $display("FAIL br_wrap: req=%b addr=%h pc=%h cnt=%0d, want req=1 addr=00 pc=00 cnt=%0d",
                     mem_req, mem_addr, pc, instr_count, exp_cnt);
        end
        wait_instr(cyc, ok);
        tests_run++;
        if (!ok || instruction !== 16'h0001) begin
            tests_failed++;
            $display("FAIL br_wrap_instr: ok=%b instr=%h, want ok=1 instr=0001", ok, instruction);
        end
    endtask

    task automatic test_run_pause;
        int cyc;
        bit ok;
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (instr_valid !== 1'b1 || pc !== 8'h00 || instruction !== 16'h0001 || mem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL pause_c%0d: iv=%b pc=%h instr=%h req=%b, want iv=1 pc=00 instr=0001 req=0",
                         i, instr_valid, pc, instruction, mem_req);
            end
        end
        run = 1'b1;
        fire_en(8'h01);
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h01 || instr_count !== exp_cnt[15:0]) begin
            tests_failed++;
            $display("FAIL resume_req: req=%b addr=%h cnt=%0d, want req=1 addr=01 cnt=%0d",
                     mem_req, mem_addr, instr_count, exp_cnt);
        end
        wait_instr(cyc, ok);
        tests_run++;
        if (!ok || instruction !== 16'hA501) begin
            tests_failed++;
            $display("FAIL resume_instr: ok=%b instr=%h, want ok=1 instr=a501", ok, instruction);
        end
    endtask

    task automatic test_en_outside_exec;
        int cyc;
        bit ok;
        lat = 3;
        fire_en(8'h05);
        en_pc  = 1'b1;
        new_pc = 8'h55;
        @(negedge clk);
        @(negedge clk);
        en_pc  = 1'b0;
        tests_run++;
        if (pc !== 8'h05 || instr_count !== exp_cnt[15:0] || instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_ignored: pc=%h cnt=%0d iv=%b, want pc=05 cnt=%0d iv=0",
                     pc, instr_count, instr_valid, exp_cnt);
        end
        wait_instr(cyc, ok);
        tests_run++;
        if (!ok || cyc != 2 || instruction !== 16'hA505) begin
            tests_failed++;
            $display("FAIL en_ignored_instr: ok=%b cyc=%0d instr=%h, want ok=1 cyc=2 instr=a505",
                     ok, cyc, instruction);
        end
    endtask

    task automatic test_reset_mid_fetch;
        int cyc;
        bit ok;
        lat = 8;
        fire_en(8'h10);
        @(negedge clk);
        tests_run++;
        if (dbg_state !== WAIT) begin
            tests_failed++;
            $display("FAIL rst_pre_state: st=%0d, want st=2", dbg_state);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b0;
        lat     = 1;
        stray_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (dbg_state !== IDLE || instr_valid !== 1'b0 || mem_req !== 1'b0 || pc !== 8'h00 ||
                instruction !== 16'h0000 || instr_count !== 16'h0000) begin
                tests_failed++;
                $display("FAIL rst_stray_c%0d: st=%0d iv=%b req=%b pc=%h instr=%h cnt=%0d, want st=0 iv=0 req=0 pc=00 instr=0000 cnt=0",
                         i, dbg_state, instr_valid, mem_req, pc, instruction, instr_count);
            end
        end
        run = 1'b1;
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_restart_req: req=%b addr=%h, want req=1 addr=00", mem_req, mem_addr);
        end
        wait_instr(cyc, ok);
        tests_run++;
        if (!ok || instruction !== 16'h0001 || instr_count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_restart_instr: ok=%b instr=%h cnt=%0d, want ok=1 instr=0001 cnt=0",
                     ok, instruction, instr_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
        mem[0] = 16'h0001;
        test_reset();
        test_first_fetch();
        test_latency();
        test_branch();
        test_run_pause();
        test_en_outside_exec();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
